// File: rtl/branch_jump_unit.sv
// Execute-stage control-transfer unit: resolves JAL/JALR/conditional branches, drives link
// writeback, a registered fetch redirect with handshake, a squash window and misaligned traps.
module branch_jump_unit #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 1,
  parameter int C_EXT        = 0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic [3:0]      i_ctrl,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_rs1_val,
  input  logic [XLEN-1:0] i_rs2_val,
  output logic            o_rd_we,
  output logic [XLEN-1:0] o_rd_val,
  output logic            o_redir_valid,
  output logic [XLEN-1:0] o_redir_pc,
  input  logic            i_redir_ready,
  output logic            o_squash,
  output logic            o_trap,
  output logic [XLEN-1:0] o_trap_val,
  output logic            o_illegal
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REDIRECT = 2'd1,
    S_SQUASH   = 2'd2
  } state_t;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] redir_pc_q, redir_pc_d;
  logic            trap_q, trap_d;
  logic [XLEN-1:0] trap_val_q, trap_val_d;
  logic            illegal_q, illegal_d;

  logic            accept;
  logic            is_nop, is_jal, is_jalr, is_br, is_illegal;
  logic            cond, taken, misaligned;
  logic [XLEN-1:0] tgt, jalr_sum;

  // Branch encodings 8,9,C..F: bits [2:1] select eq/lt/ltu, bit 0 inverts the result.
  always_comb begin
    accept     = i_valid && (state_q == S_IDLE);
    is_nop     = (i_ctrl == 4'h0);
    is_jal     = (i_ctrl == 4'h1);
    is_jalr    = (i_ctrl == 4'h2);
    is_br      = i_ctrl[3] && (i_ctrl[2] || !i_ctrl[1]);
    is_illegal = !(is_nop || is_jal || is_jalr || is_br);

    cond = 1'b0;
    case (i_ctrl[2:1])
      2'b00:   cond = (i_rs1_val == i_rs2_val);
      2'b10:   cond = ($signed(i_rs1_val) < $signed(i_rs2_val));
      2'b11:   cond = (i_rs1_val < i_rs2_val);
      default: cond = 1'b0;
    endcase
    cond = cond ^ i_ctrl[0];

    taken    = is_jal || is_jalr || (is_br && cond);
    jalr_sum = i_rs1_val + i_imm;
    tgt      = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (i_pc + i_imm);
    misaligned = (C_EXT != 0) ? tgt[0] : (|tgt[1:0]);

    o_rd_we  = accept && (is_jal || is_jalr) && !misaligned;
    o_rd_val = o_rd_we ? (i_pc + XLEN'(4)) : '0;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    redir_pc_d = redir_pc_q;
    trap_d     = 1'b0;
    trap_val_d = trap_val_q;
    illegal_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_illegal) begin
            illegal_d = 1'b1;
          end else if (taken) begin
            if (misaligned) begin
              trap_d     = 1'b1;
              trap_val_d = tgt;
            end else begin
              state_d    = S_REDIRECT;
              redir_pc_d = tgt;
            end
          end
        end
      end
      S_REDIRECT: begin
        if (i_redir_ready) begin
          if (FLUSH_CYCLES == 0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_SQUASH;
            cnt_d   = FLUSH_INIT;
          end
        end
      end
      S_SQUASH: begin
        if (cnt_q <= 4'd1) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      redir_pc_q <= '0;
      trap_q     <= 1'b0;
      trap_val_q <= '0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      redir_pc_q <= redir_pc_d;
      trap_q     <= trap_d;
      trap_val_q <= trap_val_d;
      illegal_q  <= illegal_d;
    end
  end

  assign o_redir_valid = (state_q == S_REDIRECT);
  assign o_redir_pc    = redir_pc_q;
  assign o_squash      = (state_q != S_IDLE);
  assign o_trap        = trap_q;
  assign o_trap_val    = trap_val_q;
  assign o_illegal     = illegal_q;

endmodule

// File: tb/tb_branch_jump_unit.sv
// Directed bench for branch_jump_unit: vector table for single ops plus stall, reset and
// compressed-alignment sequences. Second instance uses C_EXT=1, FLUSH_CYCLES=0.
module tb_branch_jump_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [3:0]  ctrl;
  logic [31:0] pc, imm, rs1, rs2;
  logic        ready;

  logic        rd_we, redir_valid, squash, trap, illegal;
  logic [31:0] rd_val, redir_pc, trap_val;
  logic        c_rd_we, c_redir_valid, c_squash, c_trap, c_illegal;
  logic [31:0] c_rd_val, c_redir_pc, c_trap_val;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  branch_jump_unit #(.XLEN(32), .FLUSH_CYCLES(1), .C_EXT(0)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_ctrl(ctrl), .i_pc(pc), .i_imm(imm),
    .i_rs1_val(rs1), .i_rs2_val(rs2), .o_rd_we(rd_we), .o_rd_val(rd_val),
    .o_redir_valid(redir_valid), .o_redir_pc(redir_pc), .i_redir_ready(ready),
    .o_squash(squash), .o_trap(trap), .o_trap_val(trap_val), .o_illegal(illegal)
  );

  branch_jump_unit #(.XLEN(32), .FLUSH_CYCLES(0), .C_EXT(1)) u_dut_c (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_ctrl(ctrl), .i_pc(pc), .i_imm(imm),
    .i_rs1_val(rs1), .i_rs2_val(rs2), .o_rd_we(c_rd_we), .o_rd_val(c_rd_val),
    .o_redir_valid(c_redir_valid), .o_redir_pc(c_redir_pc), .i_redir_ready(ready),
    .o_squash(c_squash), .o_trap(c_trap), .o_trap_val(c_trap_val), .o_illegal(c_illegal)
  );

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] pc, imm, rs1, rs2;
    logic        rd_we;
    logic [31:0] rd_val;
    logic        redir;
    logic [31:0] tgt;
    logic        trap;
    logic [31:0] tval;
    logic        ill;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] c, input logic [31:0] p, input logic [31:0] i,
                       input logic [31:0] a, input logic [31:0] b);
    valid = 1'b1; ctrl = c; pc = p; imm = i; rs1 = a; rs2 = b;
  endtask

  task automatic idle_inputs();
    valid = 1'b0; ctrl = 4'h0; pc = '0; imm = '0; rs1 = '0; rs2 = '0;
  endtask

  // Counts squash-high cycles of the main instance until both instances are idle.
  task automatic drain(input string name, input int sq_start, input int exp_sq);
    int sq;
    bit done;
    sq = sq_start;
    done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(posedge clk); #1;
      if (!squash && !c_squash) done = 1;
      else if (squash) sq++;
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL %s_timeout: actual=busy required=idle", name);
    end
    check({name, "_sq_cycles"}, 32'(sq), 32'(exp_sq));
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    string nm;
    v  = vecs[idx];
    nm = $sformatf("v%0d", idx);
    @(negedge clk);
    ready = 1'b1;
    drive(v.ctrl, v.pc, v.imm, v.rs1, v.rs2);
    #1;
    check({nm, "_rd_we"},  32'(rd_we), 32'(v.rd_we));
    check({nm, "_rd_val"}, rd_val, v.rd_val);
    @(posedge clk); #1;
    check({nm, "_redir_valid"}, 32'(redir_valid), 32'(v.redir));
    if (v.redir) check({nm, "_redir_pc"}, redir_pc, v.tgt);
    check({nm, "_trap"},     32'(trap), 32'(v.trap));
    check({nm, "_trap_val"}, trap_val, v.tval);
    check({nm, "_illegal"},  32'(illegal), 32'(v.ill));
    check({nm, "_squash"},   32'(squash), 32'(v.redir));
    @(negedge clk);
    idle_inputs();
    drain(nm, squash ? 1 : 0, v.redir ? 2 : 0);
  endtask

  initial begin
    vecs[0]  = '{4'h1, 32'h100, 32'h20, 32'h0, 32'h0, 1'b1, 32'h104, 1'b1, 32'h120, 1'b0, 32'h0, 1'b0};
    vecs[1]  = '{4'h2, 32'h10, 32'h0, 32'h203, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h202, 1'b0};
    vecs[2]  = '{4'hC, 32'h200, 32'h10, 32'hFFFFFFFF, 32'h1, 1'b0, 32'h0, 1'b1, 32'h210, 1'b0, 32'h202, 1'b0};
    vecs[3]  = '{4'hE, 32'h200, 32'h10, 32'hFFFFFFFF, 32'h1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h202, 1'b0};
    vecs[4]  = '{4'h8, 32'h40, 32'hFFFFFFF8, 32'h5, 32'h5, 1'b0, 32'h0, 1'b1, 32'h38, 1'b0, 32'h202, 1'b0};
    vecs[5]  = '{4'h9, 32'h40, 32'hFFFFFFF8, 32'h5, 32'h5, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h202, 1'b0};
    vecs[6]  = '{4'hD, 32'h1000, 32'h100, 32'h1, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b1, 32'h1100, 1'b0, 32'h202, 1'b0};
    vecs[7]  = '{4'hF, 32'h1000, 32'h100, 32'h1, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h202, 1'b0};
    vecs[8]  = '{4'h5, 32'h500, 32'h3, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h202, 1'b1};
    vecs[9]  = '{4'hA, 32'h500, 32'h3, 32'h7, 32'h7, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h202, 1'b1};
    vecs[10] = '{4'h0, 32'h100, 32'h2, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h202, 1'b0};
    vecs[11] = '{4'h2, 32'h80, 32'h3, 32'h1001, 32'h0, 1'b1, 32'h84, 1'b1, 32'h1004, 1'b0, 32'h202, 1'b0};
    vecs[12] = '{4'h1, 32'h100, 32'h2, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h102, 1'b0};
    vecs[13] = '{4'h8, 32'h0, 32'h6, 32'h7, 32'h7, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h6, 1'b0};
    vecs[14] = '{4'h9, 32'h0, 32'h6, 32'h7, 32'h7, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h6, 1'b0};
    vecs[15] = '{4'h1, 32'hFFFFFFFC, 32'h8, 32'h0, 32'h0, 1'b1, 32'h0, 1'b1, 32'h4, 1'b0, 32'h6, 1'b0};
    vecs[16] = '{4'hE, 32'h20, 32'h20, 32'h1, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b1, 32'h40, 1'b0, 32'h6, 1'b0};
    vecs[17] = '{4'hC, 32'h20, 32'h20, 32'h1, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h6, 1'b0};

    rst = 1'b1;
    ready = 1'b0;
    idle_inputs();
    #12;
    check("rst_redir_valid", 32'(redir_valid), 32'h0);
    check("rst_squash",      32'(squash), 32'h0);
    check("rst_trap",        32'(trap), 32'h0);
    check("rst_illegal",     32'(illegal), 32'h0);
    check("rst_redir_pc",    redir_pc, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) run_vec(i);

    // Fetch stalls three cycles; a second op presented while busy must be ignored.
    @(negedge clk);
    ready = 1'b0;
    drive(4'h1, 32'h300, 32'h40, 32'h0, 32'h0);
    #1;
    check("stall_rd_we", 32'(rd_we), 32'h1);
    @(posedge clk); #1;
    check("stall_valid0", 32'(redir_valid), 32'h1);
    check("stall_pc0",    redir_pc, 32'h340);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      drive(4'h1, 32'h0, 32'h8, 32'h0, 32'h0);
      #1;
      check($sformatf("stall_ign_rd_we%0d", k), 32'(rd_we), 32'h0);
      @(posedge clk); #1;
      check($sformatf("stall_valid%0d", k), 32'(redir_valid), 32'h1);
      check($sformatf("stall_pc%0d", k),    redir_pc, 32'h340);
      check($sformatf("stall_squash%0d", k), 32'(squash), 32'h1);
    end
    @(negedge clk);
    idle_inputs();
    ready = 1'b1;
    @(posedge clk); #1;
    check("stall_hs_valid",   32'(redir_valid), 32'h0);
    check("stall_hs_squash",  32'(squash), 32'h1);
    check("stall_c_squash",   32'(c_squash), 32'h0);
    @(posedge clk); #1;
    check("stall_done_squash", 32'(squash), 32'h0);

    // Async reset between edges while a redirect is pending.
    @(negedge clk);
    ready = 1'b0;
    drive(4'h1, 32'h600, 32'h10, 32'h0, 32'h0);
    @(posedge clk); #1;
    check("arst_pre_valid", 32'(redir_valid), 32'h1);
    idle_inputs();
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid",    32'(redir_valid), 32'h0);
    check("arst_squash",   32'(squash), 32'h0);
    check("arst_redir_pc", redir_pc, 32'h0);
    check("arst_trap_val", trap_val, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    ready = 1'b1;
    drive(4'h8, 32'h40, 32'hFFFFFFF8, 32'h5, 32'h5);
    @(posedge clk); #1;
    check("arst_post_valid", 32'(redir_valid), 32'h1);
    check("arst_post_pc",    redir_pc, 32'h38);
    @(negedge clk);
    idle_inputs();
    drain("arst_post", 1, 2);

    // JALR to 0x202: trap with 32-bit alignment, redirect with 16-bit alignment.
    @(negedge clk);
    ready = 1'b1;
    drive(4'h2, 32'h10, 32'h0, 32'h203, 32'h0);
    #1;
    check("cext_rd_we", 32'(c_rd_we), 32'h1);
    check("cext_rd_val", c_rd_val, 32'h14);
    @(posedge clk); #1;
    check("cext_redir_valid", 32'(c_redir_valid), 32'h1);
    check("cext_redir_pc",    c_redir_pc, 32'h202);
    check("cext_trap",        32'(c_trap), 32'h0);
    check("nocext_trap",      32'(trap), 32'h1);
    check("nocext_redir",     32'(redir_valid), 32'h0);
    @(negedge clk);
    idle_inputs();
    @(posedge clk); #1;
    check("cext_idle", 32'(c_squash), 32'h0);
    check("trap_pulse_end", 32'(trap), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
